// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Bus-side initiator/arbiter for the shared snoop bus of a 4-core MESI
//   system. It arbitrates core miss/upgrade requests round-robin and drives
//   one BusRd/BusRdX/Invalidate command plus Address_Com to all caches. It
//   collects snoop acknowledges and Shared responses from the other caches,
//   then pulses Done (with the aggregated Shared bit) to the owner.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   Req[i]                core i request, held until Done[i]
//   Req_type[2i+1:2i]     01 BusRd, 10 BusRdX, 11 Invalidate, 00 none
//   Req_addr[i]           core i line address (ADDR_W bits per core)
//   Snoop_ack[i]          cache i finished its snoop update
//   Snoop_shared[i]       cache i held the line valid (qualified by ack)
//   Grant                 one-hot bus owner during SNOOP
//   BusRd/BusRdX/Invalidate  bus command, at most one high
//   Address_Com           common snoop address
//   Done                  one-cycle completion pulse to the owner
//   Shared                aggregated shared response, valid with Done
//   Timeout_err           pulses with Done on a timed-out transaction
//
// Optional build macro: SNOOP_TIMEOUT_EN enables the SNOOP watchdog.
module snoop_bus_arbiter #(
  parameter int NUM_CORES     = 4,
  parameter int ADDR_W        = 32,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        Req,
  input  logic [2*NUM_CORES-1:0]      Req_type,
  input  logic [NUM_CORES*ADDR_W-1:0] Req_addr,
  input  logic [NUM_CORES-1:0]        Snoop_ack,
  input  logic [NUM_CORES-1:0]        Snoop_shared,
  output logic [NUM_CORES-1:0]        Grant,
  output logic                        BusRd,
  output logic                        BusRdX,
  output logic                        Invalidate,
  output logic [ADDR_W-1:0]           Address_Com,
  output logic [NUM_CORES-1:0]        Done,
  output logic                        Shared,
  output logic                        Timeout_err
);

  localparam int unsigned NC    = NUM_CORES;
  localparam int          IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNOOP    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [NUM_CORES-1:0]   grant_q;
  logic [NUM_CORES-1:0]   done_q;
  logic [NUM_CORES-1:0]   ack_seen_q;
  logic [NUM_CORES-1:0]   shared_seen_q;
  logic                   busrd_q;
  logic                   busrdx_q;
  logic                   inv_q;
  logic                   shared_q;
  logic [ADDR_W-1:0]      addr_q;

  logic [NUM_CORES-1:0]   elig;
  logic [NUM_CORES-1:0]   qual_ack;
  logic [NUM_CORES-1:0]   ack_seen_d;
  logic [NUM_CORES-1:0]   shared_seen_d;
  logic [IDX_W-1:0]       pick_d;
  logic                   pick_valid;
  logic [1:0]             pick_type;
  logic [ADDR_W-1:0]      pick_addr;
  logic                   acks_done;
  logic                   tmo_hit;

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NC; i++) begin
      elig[i] = Req[i] & (|Req_type[2*i +: 2]);
    end
  end

  // Round-robin scan starting just after the last owner.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_d     = ptr_q;
    for (int unsigned k = 1; k <= NC; k++) begin
      idx = (32'(ptr_q) + k) % NC;
      if (!pick_valid && elig[IDX_W'(idx)]) begin
        pick_valid = 1'b1;
        pick_d     = IDX_W'(idx);
      end
    end
  end

  assign pick_type = Req_type[{pick_d, 1'b0} +: 2];
  assign pick_addr = Req_addr[ADDR_W*pick_d +: ADDR_W];

  // Grant doubles as the owner mask: the owner's own ack/shared never count.
  assign qual_ack      = Snoop_ack & ~grant_q;
  assign ack_seen_d    = ack_seen_q | qual_ack;
  assign shared_seen_d = shared_seen_q | (Snoop_shared & qual_ack);
  assign acks_done     = &(ack_seen_d | grant_q);

`ifdef SNOOP_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(SNOOP_TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_err_q;
  // cnt_q is 0 in the first SNOOP cycle, so the forced completion lands
  // SNOOP_TIMEOUT cycles after SNOOP entry.
  assign tmo_hit     = (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
  assign Timeout_err = tmo_err_q;
`else
  assign tmo_hit     = 1'b0;
  assign Timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= IDX_W'(NUM_CORES - 1);
      grant_q       <= '0;
      done_q        <= '0;
      ack_seen_q    <= '0;
      shared_seen_q <= '0;
      busrd_q       <= 1'b0;
      busrdx_q      <= 1'b0;
      inv_q         <= 1'b0;
      shared_q      <= 1'b0;
      addr_q        <= '0;
`ifdef SNOOP_TIMEOUT_EN
      cnt_q         <= '0;
      tmo_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            ptr_q    <= pick_d;
            grant_q  <= NUM_CORES'(1) << pick_d;
            busrd_q  <= (pick_type == 2'b01);
            busrdx_q <= (pick_type == 2'b10);
            inv_q    <= (pick_type == 2'b11);
            addr_q   <= pick_addr;
            state_q  <= ST_SNOOP;
`ifdef SNOOP_TIMEOUT_EN
            cnt_q    <= '0;
`endif
          end
        end
        ST_SNOOP: begin
          ack_seen_q    <= ack_seen_d;
          shared_seen_q <= shared_seen_d;
          if (acks_done || tmo_hit) begin
            grant_q  <= '0;
            busrd_q  <= 1'b0;
            busrdx_q <= 1'b0;
            inv_q    <= 1'b0;
            done_q   <= grant_q;
            shared_q <= busrd_q & (|shared_seen_d);
            state_q  <= ST_COMPLETE;
`ifdef SNOOP_TIMEOUT_EN
            tmo_err_q <= ~acks_done;
`endif
          end else begin
`ifdef SNOOP_TIMEOUT_EN
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        ST_COMPLETE: begin
          done_q        <= '0;
          shared_q      <= 1'b0;
          ack_seen_q    <= '0;
          shared_seen_q <= '0;
          state_q       <= ST_IDLE;
`ifdef SNOOP_TIMEOUT_EN
          tmo_err_q     <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Grant       = grant_q;
  assign BusRd       = busrd_q;
  assign BusRdX      = busrdx_q;
  assign Invalidate  = inv_q;
  assign Address_Com = addr_q;
  assign Done        = done_q;
  assign Shared      = shared_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   Req = '0;
  logic [7:0]   Req_type = '0;
  logic [127:0] Req_addr = '0;
  logic [3:0]   Snoop_ack = '0;
  logic [3:0]   Snoop_shared = '0;
  logic [3:0]   Grant;
  logic         BusRd, BusRdX, Invalidate;
  logic [31:0]  Address_Com;
  logic [3:0]   Done;
  logic         Shared, Timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  snoop_bus_arbiter #(.NUM_CORES(4), .ADDR_W(32), .SNOOP_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .Req(Req), .Req_type(Req_type), .Req_addr(Req_addr),
    .Snoop_ack(Snoop_ack), .Snoop_shared(Snoop_shared), .Grant(Grant),
    .BusRd(BusRd), .BusRdX(BusRdX), .Invalidate(Invalidate),
    .Address_Com(Address_Com), .Done(Done), .Shared(Shared), .Timeout_err(Timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int          m_phase;   // 0 bus free, 1 command on bus, 2 completion cycle
  int          m_own, m_ptr, m_type, m_cnt;
  int          m_seen, m_shs;
  logic [3:0]  m_grant, m_done;
  logic        m_rd, m_rdx, m_inv, m_sh, m_to;
  logic [31:0] m_addr;

  task automatic model_step();
    bit found;
    bit all_in;
    bit timed;
    int c;
    if (!rst_n) begin
      m_phase = 0; m_ptr = 3; m_own = 0; m_type = 0; m_cnt = 0;
      m_seen = 0; m_shs = 0; m_grant = '0; m_done = '0;
      m_rd = 0; m_rdx = 0; m_inv = 0; m_sh = 0; m_to = 0; m_addr = '0;
      return;
    end
    m_done = '0; m_sh = 0; m_to = 0;
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_ptr + k) % 4;
          if (!found && Req[c] && Req_type[2*c +: 2] != 2'b00) begin
            found = 1;
            m_own = c; m_ptr = c;
            m_type = int'(Req_type[2*c +: 2]);
            m_addr = Req_addr[32*c +: 32];
          end
        end
        if (found) begin
          m_grant = 4'(1 << m_own);
          m_rd = (m_type == 1); m_rdx = (m_type == 2); m_inv = (m_type == 3);
          m_seen = 0; m_shs = 0; m_cnt = 0; m_phase = 1;
        end
      end
      1: begin
        for (int j = 0; j < 4; j++) begin
          if (j != m_own && Snoop_ack[j]) begin
            m_seen = m_seen | (1 << j);
            if (Snoop_shared[j]) m_shs = m_shs | (1 << j);
          end
        end
        all_in = ((m_seen | (1 << m_own)) == 15);
        m_cnt++;
        timed = 0;
`ifdef SNOOP_TIMEOUT_EN
        timed = (m_cnt >= 15);
`endif
        if (all_in || timed) begin
          m_grant = '0; m_rd = 0; m_rdx = 0; m_inv = 0;
          m_done = 4'(1 << m_own);
          m_sh = (m_type == 1) && (m_shs != 0);
          m_to = !all_in;
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- per-cycle compare against the model ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("Grant", 64'(Grant), 64'(m_grant));
      chk("BusRd", 64'(BusRd), 64'(m_rd));
      chk("BusRdX", 64'(BusRdX), 64'(m_rdx));
      chk("Invalidate", 64'(Invalidate), 64'(m_inv));
      chk("Address_Com", 64'(Address_Com), 64'(m_addr));
      chk("Done", 64'(Done), 64'(m_done));
      chk("Shared", 64'(Shared), 64'(m_sh));
      chk("Timeout_err", 64'(Timeout_err), 64'(m_to));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    Req = '0; Req_type = '0; Snoop_ack = '0; Snoop_shared = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [3:0] g, output int t);
    g = '0; t = cyc;
    for (int i = 0; i < 60; i++) begin
      if (Grant != 4'b0000) begin
        g = Grant; t = cyc;
        return;
      end
      @(negedge clk);
    end
    chk("wait_grant_timeout", 64'(Grant), 64'hF);
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && Req != 4'b0000; i++) begin
      @(negedge clk);
      Req = Req & ~Done;
    end
    chk("drain_all_served", 64'(Req), 64'h0);
  endtask

  logic [3:0] g;
  int         t, tprev;
  int         order [5] = '{0, 1, 2, 3, 0};
  logic [3:0] sch [5] = '{4'b0101, 4'b0100, 4'b1000, 4'b0000, 4'b0010};
  int         hold [4];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_Grant", 64'(Grant), 64'h0);
    chk("reset_Done", 64'(Done), 64'h0);
    chk("reset_Addr", 64'(Address_Com), 64'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // single BusRd from core 0
    Req = 4'b0001; Req_type = 8'h01; Req_addr[31:0] = 32'h0000_1A40;
    @(negedge clk);
    chk("t1_BusRd", 64'(BusRd), 64'h1);
    chk("t1_Grant", 64'(Grant), 64'h1);
    chk("t1_Addr", 64'(Address_Com), 64'h0000_1A40);
    chk("t1_pin_model_grant", 64'(m_grant), 64'h1);
    Snoop_ack = 4'b1110; Snoop_shared = 4'b0100;
    @(negedge clk);
    chk("t1_Done", 64'(Done), 64'h1);
    chk("t1_Shared", 64'(Shared), 64'h1);
    chk("t1_pin_model_shared", 64'(m_sh), 64'h1);
    Req = '0; Snoop_ack = '0; Snoop_shared = '0;
    @(negedge clk);

    // all four cores BusRdX, immediate acks, core 0 keeps requesting
    do_reset();
    Req = 4'b1111; Req_type = 8'hAA;
    for (int i = 0; i < 4; i++) Req_addr[32*i +: 32] = 32'h100 * (i + 1);
    Snoop_ack = 4'hF; Snoop_shared = 4'hF;
    tprev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g, t);
      chk("t2_grant_order", 64'(g), 64'(1 << order[n]));
      chk("t2_BusRdX", 64'(BusRdX), 64'h1);
      if (n > 0) chk("t2_grant_gap", 64'(t - tprev), 64'd3);
      tprev = t;
      @(negedge clk);
      chk("t2_Done", 64'(Done), 64'(g));
      chk("t2_Shared", 64'(Shared), 64'h0);
      if (n != 0) Req = Req & ~g;
    end
    Req = '0; Snoop_ack = '0; Snoop_shared = '0;
    @(negedge clk);

    // Invalidate from core 2 with staggered acks
    Req = 4'b0100; Req_type = 8'h30; Req_addr[95:64] = 32'hDEAD_0080;
    wait_grant(g, t);
    chk("t3_Grant", 64'(g), 64'h4);
    Snoop_shared = 4'hF;
    for (int s = 0; s < 5; s++) begin
      chk("t3_Invalidate_held", 64'(Invalidate), 64'h1);
      Snoop_ack = sch[s];
      @(negedge clk);
    end
    chk("t3_Done", 64'(Done), 64'h4);
    chk("t3_Shared", 64'(Shared), 64'h0);
    chk("t3_Invalidate_low", 64'(Invalidate), 64'h0);
    Req = '0; Snoop_ack = '0; Snoop_shared = '0;
    @(negedge clk);

    // asynchronous reset during SNOOP
    do_reset();
    Req = 4'b0001; Req_type = 8'h01; Req_addr[31:0] = 32'h0000_2000;
    Req_addr[127:96] = 32'h0000_3000;
    wait_grant(g, t);
    chk("t4_first_grant", 64'(g), 64'h1);
    @(negedge clk);
    Req = 4'b1001; Req_type = 8'h41;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_Grant", 64'(Grant), 64'h0);
    chk("t4_async_BusRd", 64'(BusRd), 64'h0);
    chk("t4_async_Addr", 64'(Address_Com), 64'h0);
    @(negedge clk);
    chk("t4_no_Done", 64'(Done), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(g, t);
    chk("t4_regrant_core0", 64'(g), 64'h1);
    Snoop_ack = 4'hF;
    drain(40);
    Snoop_ack = '0;
    @(negedge clk);

    // type 00 request is ignored
    Req = 4'b0010; Req_type = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_grant", 64'({Grant, Done, BusRd, BusRdX, Invalidate}), 64'h0);
    end
    Req = '0;

`ifdef SNOOP_TIMEOUT_EN
    // one cache never acknowledges
    Req = 4'b0010; Req_type = 8'h04; Req_addr[63:32] = 32'h0000_5540;
    Snoop_ack = 4'b0111; Snoop_shared = 4'b0001;
    wait_grant(g, t);
    for (int i = 0; i < 40 && Done == 4'b0000; i++) @(negedge clk);
    chk("t6_timeout_latency", 64'(cyc - t), 64'd15);
    chk("t6_Done", 64'(Done), 64'h2);
    chk("t6_Timeout_err", 64'(Timeout_err), 64'h1);
    chk("t6_Shared", 64'(Shared), 64'h1);
    Req = '0; Snoop_ack = '0; Snoop_shared = '0;
    @(negedge clk);
`endif

    // randomized traffic
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (Req[i]) begin
          if (Done[i]) Req[i] = 1'b0;
          else if (Req_type[2*i +: 2] == 2'b00) begin
            hold[i]--;
            if (hold[i] <= 0) Req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          Req_type[2*i +: 2] = 2'($urandom_range(0, 3));
          Req_addr[32*i +: 32] = $urandom;
          hold[i] = int'($urandom_range(1, 6));
          Req[i] = 1'b1;
        end
      end
      Snoop_ack = 4'($urandom_range(0, 15));
      Snoop_shared = 4'($urandom_range(0, 15));
    end
    for (int i = 0; i < 4; i++)
      if (Req_type[2*i +: 2] == 2'b00) Req[i] = 1'b0;
    Snoop_ack = 4'hF;
    drain(80);
    Snoop_ack = '0; Snoop_shared = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Bus-side initiator/arbiter for the shared snoop bus in the 4-core MESI system.
- Accepts miss/upgrade requests from each core's cache, arbitrates round-robin, and drives one BusRd/BusRdX/Invalidate command plus Address_Com to all caches.
- Collects per-cache snoop acknowledges and Shared responses, then returns Done and the aggregated Shared bit to the requesting core.

Parameters:
- NUM_CORES, 4, number of caches on the snoop bus.
- ADDR_W, 32, address width; matches ADDRESSSIZE.
- SNOOP_TIMEOUT, 15, max cycles in SNOOP before forced completion (optional feature only).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Req  in  NUM_CORES  per-core request; held until that core's Done.
- Req_type  in  2*NUM_CORES  per core, bits [2i+1:2i]: 01 BusRd, 10 BusRdX, 11 Invalidate, 00 none.
- Req_addr  in  NUM_CORES*ADDR_W  per core, bits [ADDR_W*(i+1)-1:ADDR_W*i].
- Snoop_ack  in  NUM_CORES  cache i has finished its snoop MESI update for the current command.
- Snoop_shared  in  NUM_CORES  cache i held the line valid (S/E/M); meaningful only with Snoop_ack[i].
- Grant  out  NUM_CORES  one-hot owner of the bus during SNOOP.
- BusRd, BusRdX, Invalidate  out  1 each  bus command; at most one high.
- Address_Com  out  ADDR_W  common snoop address.
- Done  out  NUM_CORES  one-cycle completion pulse to the owner.
- Shared  out  1  aggregated shared response; valid only in the Done cycle.
- Timeout_err  out  1  one-cycle pulse with Done on a timed-out transaction.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all outputs 0, ack/shared sticky registers 0, round-robin pointer = NUM_CORES-1 (core 0 has first priority), timeout counter 0.
- A core is eligible when Req[i]=1 and Req_type[i]!=00. Req with type 00 is ignored.
- FSM states: IDLE, SNOOP, COMPLETE.
- IDLE:
  - If any core is eligible, pick the first eligible core scanning from pointer+1 with wrap-around.
  - Register the winner, its type and its address; set pointer = winner; go to SNOOP.
  - Otherwise stay in IDLE.
- SNOOP:
  - Outputs are registered: Grant[w]=1, exactly the decoded command line high, Address_Com = latched address.
  - Outputs are stable for the whole state and are not affected by input changes, including the winner dropping Req.
  - Each cycle, ack_seen |= Snoop_ack & ~winner_mask and shared_seen |= Snoop_shared & Snoop_ack & ~winner_mask.
  - The winner's own Snoop_ack and Snoop_shared are ignored.
  - When (ack_seen | current qualified acks | winner_mask) is all ones, go to COMPLETE. Acks arriving in the first SNOOP cycle count.
- COMPLETE (one cycle):
  - Grant and all command lines are 0; Address_Com holds its value.
  - Done[w]=1.
  - Shared = |shared_seen when the command was BusRd; Shared = 0 for BusRdX and Invalidate.
  - Clear the sticky registers, then go to IDLE.
- Latency: request sampled in IDLE at cycle N; command on the bus at N+1; with all acks at N+1, Done at N+2; IDLE at N+3. A competing request therefore gets Grant no earlier than N+4.
- Simultaneous requests: the round-robin order above applies. A request arriving while the bus is busy waits and is never dropped.
- Acks arriving outside SNOOP are ignored.
- Reset asserted mid-transaction: immediate return to reset values; no Done is issued, and the requester must re-request.
- Requesters must hold Req_type and Req_addr stable from Req rise until Done. The latched copy is used regardless.

Optional Feature:
- SNOOP_TIMEOUT_EN defined:
  - A 4-bit+ counter runs while in SNOOP and clears on entry to SNOOP.
  - If it reaches SNOOP_TIMEOUT before all acks arrive, go to COMPLETE.
  - Done and Timeout_err pulse together; Shared is computed from the acks seen so far.
- SNOOP_TIMEOUT_EN undefined: no counter; SNOOP waits indefinitely; Timeout_err is tied to 0.

Test Plan:
- Reset then single BusRd: Req=0001, type0=01, addr0=0x0000_1A40, Snoop_ack=1110 and Snoop_shared=0100 at N+1 -> BusRd=1, Grant=0001, Address_Com=0x0000_1A40 at N+1; Done=0001 and Shared=1 at N+2.
- Simultaneous Req=1111, all type BusRdX, acks immediate -> grant order core0, 1, 2, 3, then core0 again on re-request; Shared=0 every time; each Grant no earlier than 3 cycles after the previous one.
- Staggered acks on Invalidate from core2: ack core0 at +1, core3 at +3, core1 at +5 -> Invalidate stays high for 5 cycles; Done=0100 on the following cycle; the winner's ack is ignored.
- Reset mid-SNOOP (rst_n low asynchronously at +2 of a BusRd) -> all outputs 0 immediately; no Done; after release, the same held Req is re-granted starting from core 0 priority.
- Req=0010 with type 00 -> no grant, all outputs 0. With SNOOP_TIMEOUT_EN and one cache never acking -> Done and Timeout_err pulse at SNOOP_TIMEOUT (15) cycles after SNOOP entry.
